// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - segment patterns, digit codes and filter state shared by encoder and decoder
package sevenseg_pkg;

  // bit6=a .. bit0=g, 1=lit
  localparam logic [6:0] SEG_D0    = 7'b1111110;
  localparam logic [6:0] SEG_D1    = 7'b0110000;
  localparam logic [6:0] SEG_D2    = 7'b1101101;
  localparam logic [6:0] SEG_D3    = 7'b1111001;
  localparam logic [6:0] SEG_D4    = 7'b0110011;
  localparam logic [6:0] SEG_D5    = 7'b1011011;
  localparam logic [6:0] SEG_D6    = 7'b1011111;
  localparam logic [6:0] SEG_D7    = 7'b1110000;
  localparam logic [6:0] SEG_D8    = 7'b1111111;
  localparam logic [6:0] SEG_D9    = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] DIGIT_BLANK   = 4'd10;
  localparam logic [3:0] DIGIT_ILLEGAL = 4'd15;

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } filt_state_e;

endpackage

// File: rtl/sevenseg_pattern_lookup.sv
// rtl/sevenseg_pattern_lookup.sv - exact-match map from segment pattern to digit code
module sevenseg_pattern_lookup
  import sevenseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       illegal,
  output logic [3:0] digit
);

  always_comb begin
    illegal = 1'b0;
    digit   = DIGIT_ILLEGAL;
    case (seg)
      SEG_D0:    digit = 4'd0;
      SEG_D1:    digit = 4'd1;
      SEG_D2:    digit = 4'd2;
      SEG_D3:    digit = 4'd3;
      SEG_D4:    digit = 4'd4;
      SEG_D5:    digit = 4'd5;
      SEG_D6:    digit = 4'd6;
      SEG_D7:    digit = 4'd7;
      SEG_D8:    digit = 4'd8;
      SEG_D9:    digit = 4'd9;
      SEG_BLANK: digit = DIGIT_BLANK;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/sevenseg_encoder.sv
// rtl/sevenseg_encoder.sv - deglitching segment-bus reader that reports each newly stable digit
module sevenseg_encoder
  import sevenseg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] digit,
  output logic       illegal,
  output logic       locked,
  output logic       overrun
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  filt_state_e   state_q, state_d;
  logic [6:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    last_pat_q;
  logic          commit;
  logic          report;
  logic          lk_illegal;
  logic [3:0]    lk_digit;

  sevenseg_pattern_lookup u_lookup (
    .seg     (cand_q),
    .illegal (lk_illegal),
    .digit   (lk_digit)
  );

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    if (seg_in != cand_q) begin
      cand_d  = seg_in;
      cnt_d   = '0;
      state_d = SETTLE;
    end else if (state_q == SETTLE) begin
      if (cnt_q == CNT_LAST) begin
        commit  = 1'b1;
        state_d = LOCKED;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // A glitch that settles back to the last committed pattern is not news.
  assign report = commit && (cand_q != last_pat_q);
  assign locked = (state_q == LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOCKED;
      cand_q     <= SEG_BLANK;
      cnt_q      <= '0;
      last_pat_q <= SEG_BLANK;
      out_valid  <= 1'b0;
      digit      <= 4'd0;
      illegal    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      if (report) begin
        last_pat_q <= cand_q;
      end
      // Single-entry output: a report only lands when the slot is empty or draining.
      if (report) begin
        if (!out_valid || out_ready) begin
          digit     <= lk_digit;
          illegal   <= lk_illegal;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_encoder.sv
// tb/tb_sevenseg_encoder.sv - directed self-checking bench for sevenseg_encoder
module tb_sevenseg_encoder;

  logic       clk;
  logic       rst;
  logic [6:0] seg_in;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] digit;
  logic       illegal;
  logic       locked;
  logic       overrun;

  int checks;
  int errors;

  sevenseg_encoder #(.STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_in    (seg_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .digit     (digit),
    .illegal   (illegal),
    .locked    (locked),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; seg_in = 7'b0000000; out_ready = 1'b1;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (digit !== 4'd0) begin errors++; $display("FAIL reset_digit got %0d exp 0", digit); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b exp 0", illegal); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL reset_locked got %b exp 1", locked); end
    rst = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_blank_noreport got %b exp 0", out_valid); end
  endtask

  task automatic test_commit_latency();
    seg_in = 7'b0110000;
    tick();
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lat_locked_first got %b exp 0", locked); end
    for (int i = 1; i < 4; i++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early_valid edge %0d got %b exp 0", i, out_valid); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_edge3_valid got %b exp 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_valid got %b exp 1", out_valid); end
    checks++; if (digit !== 4'd1) begin errors++; $display("FAIL lat_digit got %0d exp 1", digit); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL lat_illegal got %b exp 0", illegal); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lat_locked got %b exp 1", locked); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_pulse_end got %b exp 0", out_valid); end
  endtask

  task automatic test_glitch();
    seg_in = 7'b1111111;
    tick();
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL glitch_locked1 got %b exp 0", locked); end
    tick();
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL glitch_locked2 got %b exp 0", locked); end
    seg_in = 7'b0110000;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL glitch_noreport cycle %0d got %b exp 0", i, out_valid); end
    end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL glitch_relock got %b exp 1", locked); end
  endtask

  task automatic test_illegal_blank();
    seg_in = 7'b1001001;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ill_valid got %b exp 1", out_valid); end
    checks++; if (digit !== 4'd15) begin errors++; $display("FAIL ill_digit got %0d exp 15", digit); end
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill_flag got %b exp 1", illegal); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ill_drain got %b exp 0", out_valid); end
    seg_in = 7'b0000000;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL blank_valid got %b exp 1", out_valid); end
    checks++; if (digit !== 4'd10) begin errors++; $display("FAIL blank_digit got %0d exp 10", digit); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL blank_illegal got %b exp 0", illegal); end
    tick();
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    seg_in = 7'b1111001;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid3 got %b exp 1", out_valid); end
    checks++; if (digit !== 4'd3) begin errors++; $display("FAIL ovr_digit3 got %0d exp 3", digit); end
    seg_in = 7'b1111111;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early got %b exp 0", overrun); end
    tick();
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", overrun); end
    checks++; if (digit !== 4'd3) begin errors++; $display("FAIL ovr_held_digit got %0d exp 3", digit); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL ovr_held_illegal got %b exp 0", illegal); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovr_held_valid got %b exp 1", out_valid); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain got %b exp 0", out_valid); end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovr_lost8 cycle %0d got %b exp 0", i, out_valid); end
    end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b exp 1", overrun); end
  endtask

  task automatic test_back_to_back();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    seg_in = 7'b1101101;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (digit !== 4'd2 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_first got valid %b digit %0d exp valid 1 digit 2", out_valid, digit); end
    seg_in = 7'b1011011;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (digit !== 4'd2) begin errors++; $display("FAIL b2b_hold got %0d exp 2", digit); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b exp 1", out_valid); end
    checks++; if (digit !== 4'd5) begin errors++; $display("FAIL b2b_digit got %0d exp 5", digit); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b exp 0", overrun); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    seg_in = 7'b1110000;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (out_valid !== 1'b1 || digit !== 4'd7) begin errors++; $display("FAIL rmid_pending got valid %b digit %0d exp valid 1 digit 7", out_valid, digit); end
    seg_in = 7'b1111011;
    tick(); tick();
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rmid_settling got %b exp 0", locked); end
    rst = 1'b1;
    seg_in = 7'b0000000;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", out_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rmid_overrun got %b exp 0", overrun); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL rmid_locked got %b exp 1", locked); end
    checks++; if (digit !== 4'd0) begin errors++; $display("FAIL rmid_digit got %0d exp 0", digit); end
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0 || locked !== 1'b1) begin errors++; $display("FAIL rmid_blank cycle %0d got valid %b locked %b exp 0 1", i, out_valid, locked); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    seg_in = 7'b0000000;
    out_ready = 1'b1;
    test_reset();
    test_commit_latency();
    test_glitch();
    test_illegal_blank();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
